// File: rtl/atendimento_terminais.sv
// Two-terminal service controller: grants, releases and per-terminal served counters.
// Optional session timeout guarded by SESSAO_TIMEOUT_EN.
module atendimento_terminais #(
    parameter int TMAX = 100,
    parameter int CW   = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          REQ,
    input  logic          TERMINAL1,
    input  logic          TERMINAL2,
    input  logic          FIM1,
    input  logic          FIM2,
    output logic          ACK,
    output logic          NACK,
    output logic          OCUP1,
    output logic          OCUP2,
    output logic [CW-1:0] ATEND1,
    output logic [CW-1:0] ATEND2,
    output logic          TOUT1,
    output logic          TOUT2
);

    typedef enum logic {
        LIVRE   = 1'b0,
        OCUPADO = 1'b1
    } estado_t;

    estado_t       est1_q, est2_q;
    logic          prio_q;
    logic          ack_q, nack_q;
    logic [CW-1:0] atend1_q, atend2_q;
    logic [CW-1:0] atend1_d, atend2_d;
    logic          elig1, elig2, tie;
    logic          grant1, grant2;
    logic          to1, to2;

    // prio_q = 0 favours terminal 1 on a tie
    assign elig1  = REQ & TERMINAL1 & (est1_q == LIVRE);
    assign elig2  = REQ & TERMINAL2 & (est2_q == LIVRE);
    assign tie    = elig1 & elig2;
    assign grant1 = elig1 & (~elig2 | ~prio_q);
    assign grant2 = elig2 & (~elig1 | prio_q);

    assign atend1_d = (&atend1_q) ? atend1_q : atend1_q + 1'b1;
    assign atend2_d = (&atend2_q) ? atend2_q : atend2_q + 1'b1;

`ifdef SESSAO_TIMEOUT_EN
    logic [15:0] tmr1_q, tmr2_q;
    logic        tout1_q, tout2_q;

    assign to1 = (est1_q == OCUPADO) & ~FIM1 & (tmr1_q == 16'(TMAX - 1));
    assign to2 = (est2_q == OCUPADO) & ~FIM2 & (tmr2_q == 16'(TMAX - 1));

    always_ff @(posedge CLK) begin
        if (RST) begin
            tmr1_q  <= '0;
            tmr2_q  <= '0;
            tout1_q <= 1'b0;
            tout2_q <= 1'b0;
        end else begin
            tout1_q <= to1;
            tout2_q <= to2;
            if (grant1)
                tmr1_q <= '0;
            else if (est1_q == OCUPADO)
                tmr1_q <= tmr1_q + 16'd1;
            if (grant2)
                tmr2_q <= '0;
            else if (est2_q == OCUPADO)
                tmr2_q <= tmr2_q + 16'd1;
        end
    end

    assign TOUT1 = tout1_q;
    assign TOUT2 = tout2_q;
`else
    assign to1   = 1'b0;
    assign to2   = 1'b0;
    assign TOUT1 = 1'b0;
    assign TOUT2 = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            est1_q   <= LIVRE;
            est2_q   <= LIVRE;
            prio_q   <= 1'b0;
            ack_q    <= 1'b0;
            nack_q   <= 1'b0;
            atend1_q <= '0;
            atend2_q <= '0;
        end else begin
            ack_q  <= grant1 | grant2;
            nack_q <= REQ & ~elig1 & ~elig2;
            if (tie)
                prio_q <= ~prio_q;
            if (grant1) begin
                est1_q   <= OCUPADO;
                atend1_q <= atend1_d;
            end else if (est1_q == OCUPADO && (FIM1 || to1)) begin
                est1_q <= LIVRE;
            end
            if (grant2) begin
                est2_q   <= OCUPADO;
                atend2_q <= atend2_d;
            end else if (est2_q == OCUPADO && (FIM2 || to2)) begin
                est2_q <= LIVRE;
            end
        end
    end

    assign ACK    = ack_q;
    assign NACK   = nack_q;
    assign OCUP1  = (est1_q == OCUPADO);
    assign OCUP2  = (est2_q == OCUPADO);
    assign ATEND1 = atend1_q;
    assign ATEND2 = atend2_q;

endmodule

// File: tb/tb_atendimento_terminais.sv
// Directed bench for atendimento_terminais: vector table plus saturation
// and session-timeout sequences.
module tb_atendimento_terminais;

    logic       CLK = 1'b0;
    logic       RST = 1'b0, REQ = 1'b0;
    logic       T1 = 1'b0, T2 = 1'b0, F1 = 1'b0, F2 = 1'b0;
    logic       ACK, NACK, OC1, OC2, TO1, TO2;
    logic [7:0] AT1, AT2;
    logic       ACKb, NACKb, OC1b, OC2b, TO1b, TO2b;
    logic [1:0] AT1b, AT2b;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    atendimento_terminais #(.TMAX(4), .CW(8)) dut (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .TERMINAL1(T1), .TERMINAL2(T2), .FIM1(F1), .FIM2(F2),
        .ACK(ACK), .NACK(NACK), .OCUP1(OC1), .OCUP2(OC2),
        .ATEND1(AT1), .ATEND2(AT2), .TOUT1(TO1), .TOUT2(TO2)
    );

    atendimento_terminais #(.TMAX(4), .CW(2)) dut_sat (
        .CLK(CLK), .RST(RST), .REQ(REQ),
        .TERMINAL1(T1), .TERMINAL2(T2), .FIM1(F1), .FIM2(F2),
        .ACK(ACKb), .NACK(NACKb), .OCUP1(OC1b), .OCUP2(OC2b),
        .ATEND1(AT1b), .ATEND2(AT2b), .TOUT1(TO1b), .TOUT2(TO2b)
    );

    typedef struct {
        logic rst, req, t1, t2, f1, f2;
        logic ack, nack, o1, o2;
        int   a1, a2;
    } vec_t;

    vec_t tv[18];

    function automatic vec_t mk(logic rst, logic req, logic t1, logic t2,
                                logic f1, logic f2, logic ack, logic nack,
                                logic o1, logic o2, int a1, int a2);
        vec_t v;
        v.rst = rst; v.req = req; v.t1 = t1; v.t2 = t2;
        v.f1 = f1; v.f2 = f2; v.ack = ack; v.nack = nack;
        v.o1 = o1; v.o2 = o2; v.a1 = a1; v.a2 = a2;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic req, input logic t1,
                        input logic t2, input logic f1, input logic f2);
        RST = rst; REQ = req; T1 = t1; T2 = t2; F1 = f1; F2 = f2;
        @(posedge CLK);
        #1;
    endtask

    logic [21:0] got_v, exp_v;
    logic        tmo;

    initial begin
        //               rst req t1 t2 f1 f2  ack nack o1 o2 a1 a2
        tv[0]  = mk(1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        tv[1]  = mk(0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 1, 0);
        tv[2]  = mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 1, 0);
        tv[3]  = mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 2, 0);
        tv[4]  = mk(0, 0, 0, 0, 1, 0,  0, 0, 0, 0, 2, 0);
        tv[5]  = mk(0, 1, 1, 1, 0, 0,  1, 0, 0, 1, 2, 1);
        tv[6]  = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2, 1);
        tv[7]  = mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 3, 1);
        tv[8]  = mk(0, 1, 1, 0, 1, 0,  0, 1, 0, 0, 3, 1);
        tv[9]  = mk(0, 1, 0, 0, 0, 0,  0, 1, 0, 0, 3, 1);
        tv[10] = mk(0, 1, 1, 1, 0, 0,  1, 0, 0, 1, 3, 2);
        tv[11] = mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 1, 4, 2);
        tv[12] = mk(0, 1, 1, 1, 0, 0,  0, 1, 1, 1, 4, 2);
        tv[13] = mk(1, 1, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0);
        tv[14] = mk(0, 1, 1, 1, 0, 0,  1, 0, 1, 0, 1, 0);
        tv[15] = mk(0, 0, 0, 0, 1, 1,  0, 0, 0, 0, 1, 0);
        tv[16] = mk(0, 1, 1, 1, 1, 1,  1, 0, 0, 1, 1, 1);
        tv[17] = mk(0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 18; i++) begin
            step(tv[i].rst, tv[i].req, tv[i].t1, tv[i].t2, tv[i].f1, tv[i].f2);
            got_v = {ACK, NACK, OC1, OC2, TO1, TO2, AT1, AT2};
            exp_v = {tv[i].ack, tv[i].nack, tv[i].o1, tv[i].o2, 2'b00,
                     8'(tv[i].a1), 8'(tv[i].a2)};
            chk($sformatf("vec%0d", i), 32'(got_v), 32'(exp_v));
        end

        // ATEND1 is 1 on both instances here; CW=2 copy must stick at 3
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 1, 0, 0, 0);
            chk($sformatf("sat_ack%0d", i), 32'({ACKb, OC1b}), 32'b11);
            chk($sformatf("sat_at1_%0d", i), 32'(AT1b), (i + 1 > 3) ? 32'd3 : 32'(i + 1));
            chk($sformatf("wide_at1_%0d", i), 32'(AT1), 32'(i + 1));
            step(0, 0, 0, 0, 1, 0);
            chk($sformatf("sat_rel%0d", i), 32'({OC1, OC1b}), 32'b00);
        end

`ifdef SESSAO_TIMEOUT_EN
        tmo = 1'b1;
`else
        tmo = 1'b0;
`endif
        step(0, 1, 0, 1, 0, 0);
        chk("to_grant", 32'({ACK, OC2, TO2}), 32'b110);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("to_hold%0d", i), 32'({OC2, TO2}), 32'b10);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("to_fall", 32'({OC2, TO2}), 32'({~tmo, tmo}));
        step(0, 0, 0, 0, 0, 0);
        chk("to_after", 32'({OC2, TO2}), 32'({~tmo, 1'b0}));
        step(0, 0, 0, 0, 0, 1);
        chk("to_clean", 32'({OC2, TO2}), 32'b00);

        step(0, 1, 0, 1, 0, 0);
        chk("fim_grant", 32'({ACK, OC2}), 32'b11);
        for (int i = 1; i <= 3; i++) begin
            step(0, 0, 0, 0, 0, 0);
            chk($sformatf("fim_hold%0d", i), 32'({OC2, TO2}), 32'b10);
        end
        step(0, 0, 0, 0, 0, 1);
        chk("fim_edge", 32'({OC2, TO2}), 32'b00);
        step(0, 0, 0, 0, 0, 0);
        chk("fim_after", 32'({OC2, TO2, TO1}), 32'b000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/atendimento_terminais.md
Name: atendimento_terminais

Overview:
Terminal-side service controller that consumes the TERMINAL1/TERMINAL2 selection lines produced by the combinational terminal selector. Each cycle with REQ high is one customer request. The block either grants a free, selected terminal or rejects the request. It tracks occupancy per terminal, accepts release from the terminals, and counts the customers served at each terminal.

Parameters:
TMAX, 100, session length in cycles before a terminal is released automatically (used only with SESSAO_TIMEOUT_EN); legal range 2..65535.
CW, 8, width of the per-terminal served counters.

Ports:
CLK  input  1  clock; all state changes on the rising edge.
RST  input  1  synchronous reset, active-high.
REQ  input  1  request strobe; every cycle sampled high is one request.
TERMINAL1  input  1  selector output: terminal 1 is acceptable for this request.
TERMINAL2  input  1  selector output: terminal 2 is acceptable for this request.
FIM1  input  1  terminal 1 finished its session (release).
FIM2  input  1  terminal 2 finished its session (release).
ACK  output  1  one-cycle pulse: the request was granted.
NACK  output  1  one-cycle pulse: the request was rejected.
OCUP1  output  1  terminal 1 is occupied.
OCUP2  output  1  terminal 2 is occupied.
ATEND1  output  CW  customers granted to terminal 1.
ATEND2  output  CW  customers granted to terminal 2.
TOUT1  output  1  one-cycle pulse: terminal 1 was released by timeout.
TOUT2  output  1  one-cycle pulse: terminal 2 was released by timeout.

Behaviour:
- Reset: on RST=1 at an edge, every output becomes 0. The tie pointer PRIO is set to terminal 1, and any timers are cleared. RST has priority over all other inputs, including while a session is active.
- Each terminal k has a 2-state FSM: LIVRE (OCUPk=0) and OCUPADO (OCUPk=1).
- LIVRE -> OCUPADO: on a grant to terminal k.
- OCUPADO -> LIVRE: on FIMk=1, or on timeout when the feature is enabled. FIMk while LIVRE is ignored.
- Eligibility is computed from registered state before the edge: elig_k = REQ & TERMINALk & ~OCUPk.
- A terminal that is released at the same edge is not eligible at that edge. The request is evaluated against the pre-edge OCUPk.
- Grant selection:
  - Exactly one terminal eligible: that terminal is granted.
  - Both eligible: the terminal indicated by PRIO is granted, and PRIO toggles.
  - PRIO changes only on tie-broken grants.
- On a grant at edge n: OCUPk=1, ACK=1 and ATENDk+1 are all visible after edge n (1-cycle latency). ACK drops after edge n+1 unless another grant occurs.
- REQ=1 with no eligible terminal, including TERMINAL1=TERMINAL2=0: NACK=1 for one cycle after the edge. No state changes.
- ACK and NACK are never high together. Both are 0 when REQ=0.
- REQ held high over several cycles is treated as back-to-back independent requests.
- ATENDk saturates at 2^CW-1 and does not wrap. Grants continue normally after saturation.
- Releases are independent: FIM1 and FIM2 may both be asserted in the same cycle, and both terminals are released.

Optional Feature:
SESSAO_TIMEOUT_EN
- Defined:
  - Each terminal has a session timer that clears on grant and increments every cycle while OCUPADO.
  - After exactly TMAX cycles with OCUPk=1 and no FIMk, the terminal returns to LIVRE. OCUPk falls after that edge and TOUTk pulses for 1 cycle, aligned with the falling OCUPk.
  - If FIMk coincides with the timeout edge, the release counts as FIM and TOUTk stays 0.
- Not defined: no timers exist, TOUT1 and TOUT2 are tied to 0, and terminals are released only by FIMk.

Test Plan:
- Reset, then REQ=1 with TERMINAL1=1, TERMINAL2=0 for one cycle -> next cycle ACK=1, OCUP1=1, ATEND1=1, OCUP2=0.
- Both terminals free, three single-cycle REQs with TERMINAL1=TERMINAL2=1, FIM1/FIM2 asserted between requests -> grants go to terminals 1, 2, 1 (PRIO alternates); ATEND1=2, ATEND2=1.
- OCUP1=1; REQ with TERMINAL1=1, TERMINAL2=0 and FIM1=1 in the same cycle -> NACK=1, OCUP1=0 afterwards, ATEND1 unchanged.
- REQ with TERMINAL1=TERMINAL2=0 -> NACK=1 for 1 cycle, no output change. Separately, CW=2 and 5 grants to terminal 1 -> ATEND1=3 (saturated).
- Both terminals occupied, RST=1 for one cycle mid-session -> all outputs 0. A following tie request is granted to terminal 1.
- SESSAO_TIMEOUT_EN, TMAX=4: grant terminal 2, no FIM2 -> OCUP2 high for exactly 4 cycles, TOUT2 pulses once as OCUP2 falls. Repeat with FIM2 on the 4th cycle -> TOUT2 stays 0.
